// File: rtl/dm_pkg.sv
// Shared types and default sizing for the MEM-stage data-memory responder.
package dm_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dm_state_t;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DEPTH_LOG2 = 12;
  localparam int DEF_RD_LAT     = 2;
  localparam int DEF_WR_LAT     = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Data-memory port between the MEM stage (master) and the responder (slave).
interface dm_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic              re;
  logic              we;
  logic [DATA_W-1:0] wrt_data;
  logic [DATA_W-1:0] rd_data;
  logic              stall;
  logic              err;

  modport master (output addr, re, we, wrt_data, input rd_data, stall, err);
  modport slave  (input addr, re, we, wrt_data, output rd_data, stall, err);
endinterface

// File: rtl/dm_array.sv
// Single-port synchronous RAM; the read register keeps its value until the next read.
module dm_array #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);
  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Contents are deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) rdata_d = mem[idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/dm_responder.sv
// Wait-state data-memory responder: accepts one load/store, stalls the pipe, then responds.
//   state | meaning
//   IDLE  | no access; accept re/we, raise stall combinationally
//   WAIT  | counting remaining stall cycles on latched request
//   RESP  | stall released; load data valid, store commits on exit
module dm_responder
  import dm_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int WR_LAT     = DEF_WR_LAT
) (
  input  logic           clk,
  input  logic           rst,
  dm_responder_if.slave  bus
);
  localparam int CNT_W = $clog2(max_int(RD_LAT, WR_LAT)) + 1;
  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LAT - 1);

  dm_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  store_q, store_d;
  logic                  err_q, err_d;
  logic                  stall;
  logic                  rd_en, wr_en;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^bus.addr[ADDR_W-1:DEPTH_LOG2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    store_d = store_q;
    err_d   = 1'b0;
    stall   = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    ram_idx = idx_q;
    case (state_q)
      IDLE: begin
        // Only a single-cycle load reads straight off the bus address.
        ram_idx = bus.addr[DEPTH_LOG2-1:0];
        if (bus.re || bus.we) begin
          stall   = 1'b1;
          idx_d   = bus.addr[DEPTH_LOG2-1:0];
          data_d  = bus.wrt_data;
          store_d = bus.we;
          err_d   = bus.re && bus.we;
          if (bus.we) begin
            cnt_d   = WR_CNT;
            state_d = (WR_LAT == 1) ? RESP : WAIT;
          end else begin
            cnt_d = RD_CNT;
            if (RD_LAT == 1) begin
              state_d = RESP;
              rd_en   = 1'b1;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = RESP;
          rd_en   = !store_q;
        end
      end
      RESP: begin
        wr_en   = store_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      store_q <= store_d;
      err_q   <= err_d;
    end
  end

  dm_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .rd_en (rd_en),
    .wr_en (wr_en),
    .idx   (ram_idx),
    .wdata (data_q),
    .rdata (bus.rd_data)
  );

  assign bus.stall = stall;
  assign bus.err   = err_q;
endmodule
